// File: rtl/pcie_msi_sched.sv
// rtl/pcie_msi_sched.sv - per-vector MSI scheduler: edge latch, mask, round-robin grant, req/ack with timeout and holdoff
module pcie_msi_sched #(
  parameter int NUM_VEC     = 8,
  parameter int HOLDOFF     = 16,
  parameter int ACK_TIMEOUT = 1024
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_VEC-1:0] irq,
  input  logic [NUM_VEC-1:0] irq_mask,
  input  logic               msi_enable,
  input  logic               err_clr,
  output logic               app_msi_req,
  output logic [4:0]         app_msi_num,
  output logic [2:0]         app_msi_tc,
  output logic               app_int_sts,
  input  logic               app_msi_ack,
  output logic [NUM_VEC-1:0] pending,
  output logic               timeout_err
);

  localparam int HW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
  localparam int TW = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'((HOLDOFF > 0) ? HOLDOFF - 1 : 0);
  localparam logic [TW-1:0] TO_LAST   = TW'(ACK_TIMEOUT - 2);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_HOLD} state_e;

  state_e             state_q, state_d;
  logic [NUM_VEC-1:0] irq_r_q;
  logic [NUM_VEC-1:0] pending_q, pending_d;
  logic               req_q, req_d;
  logic [4:0]         num_q, num_d;
  logic [4:0]         last_q, last_d;
  logic [HW-1:0]      hold_cnt_q, hold_cnt_d;
  logic [TW-1:0]      to_cnt_q, to_cnt_d;
  logic               err_q, err_d;

  logic [NUM_VEC-1:0] rise, eligible, clr;
  logic               hi_vld, lo_vld, grant_vld, timeout;
  logic [4:0]         hi_idx, lo_idx, grant_idx;

  assign rise     = irq & ~irq_r_q;
  assign eligible = pending_q & ~irq_mask;

  // Round-robin: lowest eligible above last, else lowest eligible overall (wrap).
  always_comb begin
    hi_vld = 1'b0;
    hi_idx = '0;
    lo_vld = 1'b0;
    lo_idx = '0;
    for (int j = 0; j < NUM_VEC; j++) begin
      if (!hi_vld && eligible[j] && (j > int'(last_q))) begin
        hi_vld = 1'b1;
        hi_idx = 5'(j);
      end
      if (!lo_vld && eligible[j]) begin
        lo_vld = 1'b1;
        lo_idx = 5'(j);
      end
    end
    grant_vld = hi_vld | lo_vld;
    grant_idx = hi_vld ? hi_idx : lo_idx;
  end

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    num_d      = num_q;
    last_d     = last_q;
    hold_cnt_d = hold_cnt_q;
    to_cnt_d   = to_cnt_q;
    clr        = '0;
    timeout    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (msi_enable && grant_vld) begin
          req_d    = 1'b1;
          num_d    = grant_idx;
          to_cnt_d = '0;
          state_d  = S_REQ;
        end
      end
      S_REQ: begin
        if (app_msi_ack) begin
          req_d      = 1'b0;
          clr        = NUM_VEC'(1) << num_q;
          last_d     = num_q;
          hold_cnt_d = '0;
          state_d    = (HOLDOFF == 0) ? S_IDLE : S_HOLD;
        end else if (to_cnt_q == TO_LAST) begin
          req_d      = 1'b0;
          timeout    = 1'b1;
          hold_cnt_d = '0;
          state_d    = (HOLDOFF == 0) ? S_IDLE : S_HOLD;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      S_HOLD: begin
        if (hold_cnt_q == HOLD_LAST) state_d = S_IDLE;
        else                         hold_cnt_d = hold_cnt_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
    // New events win over the ack clear; a new timeout wins over err_clr.
    pending_d = (pending_q & ~clr) | rise;
    err_d     = timeout ? 1'b1 : (err_clr ? 1'b0 : err_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      irq_r_q    <= '0;
      pending_q  <= '0;
      req_q      <= 1'b0;
      num_q      <= '0;
      last_q     <= 5'(NUM_VEC - 1);
      hold_cnt_q <= '0;
      to_cnt_q   <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      irq_r_q    <= irq;
      pending_q  <= pending_d;
      req_q      <= req_d;
      num_q      <= num_d;
      last_q     <= last_d;
      hold_cnt_q <= hold_cnt_d;
      to_cnt_q   <= to_cnt_d;
      err_q      <= err_d;
    end
  end

  assign app_msi_req = req_q;
  assign app_msi_num = num_q;
  assign app_msi_tc  = 3'd0;
  assign app_int_sts = 1'b0;
  assign pending     = pending_q;
  assign timeout_err = err_q;

endmodule

// File: tb/tb_pcie_msi_sched.sv
// tb/tb_pcie_msi_sched.sv - directed bench for pcie_msi_sched
module tb_pcie_msi_sched;
  logic       clk = 1'b0;
  logic       reset, msi_enable, err_clr, ack;
  logic [7:0] irq, mask;

  logic       req_a, sts_a, err_a, req_b, sts_b, err_b;
  logic [4:0] num_a, num_b;
  logic [2:0] tc_a, tc_b;
  logic [7:0] pend_a, pend_b;

  int tests = 0;
  int fails = 0;
  int cnt;

  always #5 clk = ~clk;

  // A: long holdoff, short timeout. B: no holdoff.
  pcie_msi_sched #(.NUM_VEC(8), .HOLDOFF(16), .ACK_TIMEOUT(8)) u_a (
    .clk(clk), .reset(reset), .irq(irq), .irq_mask(mask),
    .msi_enable(msi_enable), .err_clr(err_clr),
    .app_msi_req(req_a), .app_msi_num(num_a), .app_msi_tc(tc_a),
    .app_int_sts(sts_a), .app_msi_ack(ack), .pending(pend_a),
    .timeout_err(err_a)
  );

  pcie_msi_sched #(.NUM_VEC(8), .HOLDOFF(0), .ACK_TIMEOUT(1024)) u_b (
    .clk(clk), .reset(reset), .irq(irq), .irq_mask(mask),
    .msi_enable(msi_enable), .err_clr(err_clr),
    .app_msi_req(req_b), .app_msi_num(num_b), .app_msi_tc(tc_b),
    .app_int_sts(sts_b), .app_msi_ack(ack), .pending(pend_b),
    .timeout_err(err_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    irq   = '0;
    ack   = 1'b0;
    step(1);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; irq = '0; mask = '0; msi_enable = 1'b1; err_clr = 1'b0; ack = 1'b0;
    step(2);
    check("rst_req", {31'd0, req_a}, 0);
    check("rst_num", {27'd0, num_a}, 0);
    check("rst_pend", {24'd0, pend_a}, 0);
    check("rst_err", {31'd0, err_a}, 0);
    check("rst_req_b", {31'd0, req_b}, 0);
    check("tc_sts", {28'd0, tc_a, sts_a}, 0);

    // Single event with holdoff 16
    reset = 1'b0; irq = 8'h08;
    step(1); irq = '0;
    check("s_pend", {24'd0, pend_a}, 32'h08);
    check("s_req_early", {31'd0, req_a}, 0);
    step(1);
    check("s_req", {31'd0, req_a}, 1);
    check("s_num", {27'd0, num_a}, 3);
    ack = 1'b1; step(1); ack = 1'b0; irq = 8'h04;
    check("s_ack_req", {31'd0, req_a}, 0);
    check("s_ack_pend", {24'd0, pend_a}, 0);
    cnt = 0;
    repeat (16) begin step(1); if (req_a) cnt++; end
    check("s_holdoff", cnt, 0);
    step(1);
    check("s_after_hold_req", {31'd0, req_a}, 1);
    check("s_after_hold_num", {27'd0, num_a}, 2);
    ack = 1'b1; irq = '0; step(1); ack = 1'b0;

    // Round-robin on B
    do_reset();
    irq = 8'h25; step(1); irq = '0;
    check("rr_pend", {24'd0, pend_b}, 32'h25);
    step(1);
    check("rr_g0", {26'd0, req_b, num_b}, {26'd0, 1'b1, 5'd0});
    ack = 1'b1; step(1); ack = 1'b0;
    step(1);
    check("rr_g2", {26'd0, req_b, num_b}, {26'd0, 1'b1, 5'd2});
    irq = 8'h01; ack = 1'b1; step(1); irq = '0; ack = 1'b0;
    step(1);
    check("rr_g5", {26'd0, req_b, num_b}, {26'd0, 1'b1, 5'd5});
    ack = 1'b1; step(1); ack = 1'b0;
    step(1);
    check("rr_g0_again", {26'd0, req_b, num_b}, {26'd0, 1'b1, 5'd0});
    ack = 1'b1; step(1); ack = 1'b0;
    check("rr_done_pend", {24'd0, pend_b}, 0);

    // Re-edge in the ack cycle on B
    do_reset();
    irq = 8'h02; step(1); irq = '0;
    step(1);
    check("re_g1", {26'd0, req_b, num_b}, {26'd0, 1'b1, 5'd1});
    irq = 8'h02; ack = 1'b1; step(1); irq = '0; ack = 1'b0;
    check("re_pend_kept", {24'd0, pend_b}, 32'h02);
    check("re_req_low", {31'd0, req_b}, 0);
    step(1);
    check("re_g1_again", {26'd0, req_b, num_b}, {26'd0, 1'b1, 5'd1});
    ack = 1'b1; step(1); ack = 1'b0;
    check("re_pend_clr", {24'd0, pend_b}, 0);

    // Mask then enable on B
    do_reset();
    mask = 8'h10; irq = 8'h10; step(1); irq = '0;
    step(2);
    check("m_pend", {24'd0, pend_b}, 32'h10);
    check("m_no_req", {31'd0, req_b}, 0);
    mask = '0; step(1);
    check("m_g4", {26'd0, req_b, num_b}, {26'd0, 1'b1, 5'd4});
    ack = 1'b1; step(1); ack = 1'b0;
    msi_enable = 1'b0;
    do_reset();
    irq = 8'h81; step(1); irq = '0;
    step(3);
    check("e_pend", {24'd0, pend_b}, 32'h81);
    check("e_no_req", {31'd0, req_b}, 0);
    msi_enable = 1'b1; step(1);
    check("e_g0", {26'd0, req_b, num_b}, {26'd0, 1'b1, 5'd0});
    ack = 1'b1; step(1); ack = 1'b0;
    step(1);
    check("e_g7", {26'd0, req_b, num_b}, {26'd0, 1'b1, 5'd7});
    ack = 1'b1; step(1); ack = 1'b0;

    // Timeout on A
    do_reset();
    irq = 8'h20; step(1); irq = '0;
    step(1);
    check("t_g5", {26'd0, req_a, num_a}, {26'd0, 1'b1, 5'd5});
    cnt = 0;
    repeat (6) begin step(1); if (req_a) cnt++; end
    check("t_held", cnt, 6);
    step(1);
    check("t_req_low", {31'd0, req_a}, 0);
    check("t_err", {31'd0, err_a}, 1);
    check("t_pend", {24'd0, pend_a}, 32'h20);
    cnt = 0;
    repeat (16) begin step(1); if (req_a) cnt++; end
    check("t_holdoff", cnt, 0);
    step(1);
    check("t_retry", {26'd0, req_a, num_a}, {26'd0, 1'b1, 5'd5});
    err_clr = 1'b1; step(1); err_clr = 1'b0;
    check("t_err_clr", {31'd0, err_a}, 0);

    // Reset in the middle of a request on A
    do_reset();
    irq = 8'h01; step(1); irq = '0;
    step(1);
    check("r_req", {31'd0, req_a}, 1);
    reset = 1'b1; step(1);
    check("r_state", {18'd0, req_a, num_a, pend_a}, 0);
    reset = 1'b0; ack = 1'b1; step(1); ack = 1'b0;
    step(2);
    check("r_after_ack", {23'd0, req_a, pend_a}, 0);
    irq = 8'h03; step(1); irq = '0;
    step(1);
    check("r_next_g0", {26'd0, req_a, num_a}, {26'd0, 1'b1, 5'd0});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
